// File: rtl/haar_stage_accumulator_pkg.sv
// Shared widths, FSM state codes and sum-range helpers for the Haar stage accumulator.
package haar_stage_accumulator_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_SUM_WIDTH  = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCUM  = 2'd1;
    localparam state_t ST_DECIDE = 2'd2;
    localparam state_t ST_RESULT = 2'd3;

    function automatic int sum_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sum_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/haar_stage_accumulator_if.sv
// Record-in / result-out bus between the classifier feed, the accumulator and the cascade controller.
interface haar_stage_accumulator_if
    import haar_stage_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SUM_WIDTH  = DEF_SUM_WIDTH
);
    logic                         i_valid;
    logic                         o_ready;
    logic signed [DATA_WIDTH-1:0] i_feature;
    logic signed [DATA_WIDTH-1:0] i_node_threshold;
    logic signed [DATA_WIDTH-1:0] i_left;
    logic signed [DATA_WIDTH-1:0] i_right;
    logic                         i_last;
    logic        [ADDR_WIDTH-1:0] i_max_size;
    logic signed [SUM_WIDTH-1:0]  i_stage_threshold;
    logic                         o_result_valid;
    logic                         i_result_ready;
    logic                         o_pass;
    logic                         o_overrun;
    logic signed [SUM_WIDTH-1:0]  o_stage_sum;

    modport master (
        output i_valid, i_feature, i_node_threshold, i_left, i_right, i_last,
               i_max_size, i_stage_threshold, i_result_ready,
        input  o_ready, o_result_valid, o_pass, o_overrun, o_stage_sum
    );

    modport slave (
        input  i_valid, i_feature, i_node_threshold, i_left, i_right, i_last,
               i_max_size, i_stage_threshold, i_result_ready,
        output o_ready, o_result_valid, o_pass, o_overrun, o_stage_sum
    );

endinterface

// File: rtl/haar_weak_vote.sv
// One weak classifier: pick the left or right vote by comparing the feature against the node threshold.
module haar_weak_vote #(
    parameter int DATA_WIDTH = 8,
    parameter int SUM_WIDTH  = 16
) (
    input  logic signed [DATA_WIDTH-1:0] feature,
    input  logic signed [DATA_WIDTH-1:0] node_threshold,
    input  logic signed [DATA_WIDTH-1:0] left,
    input  logic signed [DATA_WIDTH-1:0] right,
    output logic signed [SUM_WIDTH-1:0]  vote
);

    assign vote = (feature < node_threshold) ? SUM_WIDTH'(left) : SUM_WIDTH'(right);

endmodule

// File: rtl/haar_stage_accumulator.sv
// Accumulates weak-classifier votes per stage with saturation and hands a pass/fail result downstream.
module haar_stage_accumulator
    import haar_stage_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SUM_WIDTH  = DEF_SUM_WIDTH
) (
    input  logic clk,
    input  logic reset,
    haar_stage_accumulator_if.slave bus
);

    localparam logic signed [SUM_WIDTH-1:0] SUM_MAX = SUM_WIDTH'(sum_max(SUM_WIDTH));
    localparam logic signed [SUM_WIDTH-1:0] SUM_MIN = SUM_WIDTH'(sum_min(SUM_WIDTH));

    function automatic logic signed [SUM_WIDTH-1:0] sat_add(
        input logic signed [SUM_WIDTH-1:0] a,
        input logic signed [SUM_WIDTH-1:0] b
    );
        logic signed [SUM_WIDTH:0] s;
        s = {a[SUM_WIDTH-1], a} + {b[SUM_WIDTH-1], b};
        if (s[SUM_WIDTH] != s[SUM_WIDTH-1])
            return s[SUM_WIDTH] ? SUM_MIN : SUM_MAX;
        return s[SUM_WIDTH-1:0];
    endfunction

    state_t                       state;
    logic                         run;
    logic                         overrun_flag;
    logic                         pass_q;
    logic                         overrun_q;
    logic signed [SUM_WIDTH-1:0]  stage_sum_q;
    logic signed [SUM_WIDTH-1:0]  sum;
    logic signed [SUM_WIDTH-1:0]  stage_thr;
    logic        [ADDR_WIDTH-1:0] count;
    logic signed [SUM_WIDTH-1:0]  vote;
    logic                         accept;
    logic                         final_beat;
    logic        [ADDR_WIDTH-1:0] count_next;
    logic signed [SUM_WIDTH-1:0]  sum_next;

    haar_weak_vote #(
        .DATA_WIDTH (DATA_WIDTH),
        .SUM_WIDTH  (SUM_WIDTH)
    ) u_weak_vote (
        .feature        (bus.i_feature),
        .node_threshold (bus.i_node_threshold),
        .left           (bus.i_left),
        .right          (bus.i_right),
        .vote           (vote)
    );

    // run keeps o_ready low while reset is held and until the first edge after release
    assign bus.o_ready        = run && (state == ST_IDLE || state == ST_ACCUM);
    assign bus.o_result_valid = (state == ST_RESULT);
    assign bus.o_pass         = pass_q;
    assign bus.o_overrun      = overrun_q;
    assign bus.o_stage_sum    = stage_sum_q;

    assign accept = bus.i_valid && bus.o_ready;

    // A wrap of count to zero matches i_max_size == 0, i.e. the full 2^ADDR_WIDTH stage
    assign count_next = (state == ST_IDLE) ? ADDR_WIDTH'(1) : count + ADDR_WIDTH'(1);
    assign sum_next   = (state == ST_IDLE) ? vote : sat_add(sum, vote);
    assign final_beat = bus.i_last || (count_next == bus.i_max_size);

    always_ff @(posedge clk) begin
        if (accept) begin
            sum   <= sum_next;
            count <= count_next;
            if (final_beat)
                stage_thr <= bus.i_stage_threshold;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            run          <= 1'b0;
            overrun_flag <= 1'b0;
            pass_q       <= 1'b0;
            overrun_q    <= 1'b0;
            stage_sum_q  <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        if (final_beat) begin
                            state        <= ST_DECIDE;
                            overrun_flag <= ~bus.i_last;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_DECIDE: begin
                    pass_q      <= (sum >= stage_thr);
                    overrun_q   <= overrun_flag;
                    stage_sum_q <= sum;
                    state       <= ST_RESULT;
                end
                default: begin
                    if (bus.i_result_ready) begin
                        state        <= ST_IDLE;
                        overrun_flag <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_haar_stage_accumulator.sv
// Randomized and directed bench for haar_stage_accumulator against a plain-arithmetic stage model.
module tb_haar_stage_accumulator;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    haar_stage_accumulator_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .SUM_WIDTH(16)) bus ();

    haar_stage_accumulator #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (12),
        .SUM_WIDTH  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic signed [7:0] fa [512];
    logic signed [7:0] ta [512];
    logic signed [7:0] la [512];
    logic signed [7:0] ra [512];

    task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic fill(input int i, input int f, input int t, input int l, input int r);
        fa[i] = 8'(f);
        ta[i] = 8'(t);
        la[i] = 8'(l);
        ra[i] = 8'(r);
    endtask

    task automatic junk_beat();
        bus.i_valid          = 1'b1;
        bus.i_feature        = 8'($urandom);
        bus.i_node_threshold = 8'($urandom);
        bus.i_left           = 8'($urandom);
        bus.i_right          = 8'($urandom);
        bus.i_last           = 1'b1;
        bus.i_stage_threshold = 16'($urandom);
    endtask

    // Entered and left at a falling edge; the next stage's first beat can go out immediately.
    task automatic run_stage(input string tag, input int last_at, input logic [11:0] maxsz,
                             input logic signed [15:0] sthr, input int hold);
        int  sum = 0;
        int  cnt = 0;
        int  lim;
        int  i = 0;
        int  v;
        bit  fin = 0;
        bit  ovf = 0;
        bit  pred;
        lim = (maxsz == 0) ? 4096 : int'(maxsz);
        bus.i_max_size = maxsz;
        while (!fin) begin
            pred = (i == last_at) || (cnt + 1 == lim);
            bus.i_valid           = 1'b1;
            bus.i_feature         = fa[i];
            bus.i_node_threshold  = ta[i];
            bus.i_left            = la[i];
            bus.i_right           = ra[i];
            bus.i_last            = (i == last_at);
            bus.i_stage_threshold = pred ? sthr : 16'($urandom);
            if (i == 0 || !bus.o_ready)
                check({tag, "_ready"}, bus.o_ready, 1);
            @(posedge clk);
            v   = (int'(fa[i]) < int'(ta[i])) ? int'(la[i]) : int'(ra[i]);
            sum = (cnt == 0) ? v : sum + v;
            if (sum > 32767)  sum = 32767;
            if (sum < -32768) sum = -32768;
            cnt++;
            fin = (i == last_at) || (cnt == lim);
            ovf = fin && (i != last_at);
            i++;
            @(negedge clk);
        end
        junk_beat();
        bus.i_result_ready = (hold == 0);
        check({tag, "_decide_ready"}, bus.o_ready, 0);
        check({tag, "_decide_valid"}, bus.o_result_valid, 0);
        @(negedge clk);
        junk_beat();
        check({tag, "_valid"}, bus.o_result_valid, 1);
        check({tag, "_sum"}, bus.o_stage_sum, sum);
        check({tag, "_pass"}, bus.o_pass, (sum >= int'(sthr)));
        check({tag, "_overrun"}, bus.o_overrun, ovf);
        check({tag, "_hold_ready"}, bus.o_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            junk_beat();
            check({tag, "_stable_valid"}, bus.o_result_valid, 1);
            check({tag, "_stable_sum"}, bus.o_stage_sum, sum);
            check({tag, "_stable_ready"}, bus.o_ready, 0);
        end
        bus.i_result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid        = 1'b0;
        bus.i_result_ready = 1'b0;
        check({tag, "_released_valid"}, bus.o_result_valid, 0);
        check({tag, "_released_ready"}, bus.o_ready, 1);
    endtask

    task automatic idle(input int n);
        bus.i_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int last_at;
        logic [11:0] maxsz;
        reset                 = 1'b0;
        bus.i_valid           = 1'b0;
        bus.i_feature         = '0;
        bus.i_node_threshold  = '0;
        bus.i_left            = '0;
        bus.i_right           = '0;
        bus.i_last            = 1'b0;
        bus.i_max_size        = '0;
        bus.i_stage_threshold = '0;
        bus.i_result_ready    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.o_ready, 0);
        check("rst_valid", bus.o_result_valid, 0);
        check("rst_pass", bus.o_pass, 0);
        check("rst_overrun", bus.o_overrun, 0);
        check("rst_sum", bus.o_stage_sum, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_release_ready", bus.o_ready, 1);

        fill(0, 5, 10, 20, -7);
        fill(1, 12, 10, 20, -7);
        fill(2, 0, 0, 3, 4);
        run_stage("basic_pass", 2, 12'd0, 16'sd16, 0);
        idle(2);
        run_stage("basic_fail_hold", 2, 12'd0, 16'sd18, 5);
        idle(1);

        for (int i = 0; i < 8; i++) fill(i, 0, 1, 1, -1);
        run_stage("overrun4", -1, 12'd4, 16'sd0, 1);
        idle(1);

        for (int i = 0; i < 300; i++) fill(i, 0, 1, 127, 0);
        run_stage("sat_pos", 299, 12'd0, 16'sd0, 0);
        for (int i = 0; i < 300; i++) fill(i, 5, 0, 0, -128);
        run_stage("sat_neg", 299, 12'd0, 16'sd0, 0);
        idle(1);

        // Leave a passing result on the outputs, then reset in the middle of the next stage
        fill(0, 1, 2, 50, 0);
        run_stage("pre_reset", 0, 12'd0, 16'sd10, 0);
        for (int i = 0; i < 2; i++) begin
            bus.i_valid          = 1'b1;
            bus.i_feature        = 8'sd1;
            bus.i_node_threshold = 8'sd2;
            bus.i_left           = 8'sd100;
            bus.i_right          = 8'sd0;
            bus.i_last           = 1'b0;
            bus.i_max_size       = 12'd0;
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        check("midrst_ready", bus.o_ready, 0);
        check("midrst_valid", bus.o_result_valid, 0);
        check("midrst_pass", bus.o_pass, 0);
        check("midrst_overrun", bus.o_overrun, 0);
        check("midrst_sum", bus.o_stage_sum, 0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        fill(0, -3, 0, 9, 1);
        fill(1, 7, 0, 9, -2);
        run_stage("after_reset", 1, 12'd0, 16'sd7, 0);

        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 6; i++)
                fill(i, $urandom_range(0, 20) - 10, $urandom_range(0, 20) - 10,
                     $urandom_range(0, 60) - 30, $urandom_range(0, 60) - 30);
            run_stage("b2b", $urandom_range(0, 5), 12'd0, 16'($urandom_range(0, 80) - 40), 0);
        end

        for (int s = 0; s < 12; s++) begin
            n = 32;
            for (int i = 0; i < n; i++)
                fill(i, int'(8'($urandom)), int'(8'($urandom)), int'(8'($urandom)), int'(8'($urandom)));
            maxsz   = ($urandom_range(0, 2) == 0) ? 12'($urandom_range(1, 20)) : 12'd0;
            last_at = (maxsz != 0 && $urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 24));
            run_stage("rand", last_at, maxsz, 16'($urandom_range(0, 800) - 400), $urandom_range(0, 3));
            idle($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/haar_stage_accumulator.md
# haar_stage_accumulator

Downstream consumer of the weak-classifier address counter in the face-detection pipeline. Per weak classifier it takes one record (feature response, node threshold, left/right votes, plus the counter-derived last flag) and accumulates the signed votes into a stage sum. At stage end it compares the sum against the stage threshold and presents a pass/fail result to the cascade controller with a valid/ready handshake. It throttles its input while a result is pending.

## Interface
- DATA_WIDTH, 8: width of feature response, node threshold and votes (signed, two's complement)
- ADDR_WIDTH, 12: width of weak-classifier count (matches counter address width)
- SUM_WIDTH, 16: width of stage sum and stage threshold (signed)

- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low; state cleared while 0
- i_valid  in  1  record beat valid
- o_ready  out  1  block accepts a beat this cycle
- i_feature  in  DATA_WIDTH  signed feature response
- i_node_threshold  in  DATA_WIDTH  signed weak-classifier threshold
- i_left  in  DATA_WIDTH  signed vote when feature < threshold
- i_right  in  DATA_WIDTH  signed vote otherwise
- i_last  in  1  last weak classifier of stage (counter end-reached, aligned to data)
- i_max_size  in  ADDR_WIDTH  expected weak classifiers per stage; 0 means 2^ADDR_WIDTH
- i_stage_threshold  in  SUM_WIDTH  signed; sampled on acceptance of the final beat
- o_result_valid  out  1  result held until accepted
- i_result_ready  in  1  downstream accepts result
- o_pass  out  1  1 when stage_sum >= stage_threshold
- o_overrun  out  1  stage was force-closed by i_max_size (no i_last)
- o_stage_sum  out  SUM_WIDTH  final saturated sum

## Operation
- States: IDLE, ACCUM, DECIDE, RESULT. o_ready = 1 in IDLE/ACCUM, 0 in DECIDE/RESULT.
- Beat accepted on edge where i_valid & o_ready.
- Vote = (signed i_feature < signed i_node_threshold) ? i_left : i_right, sign-extended to SUM_WIDTH.
- IDLE: on accepted beat, sum <= vote (fresh start), beat count <= 1, go ACCUM (or DECIDE if final).
- ACCUM: on accepted beat, sum <= sat(sum + vote), count += 1.
- Final beat: i_last = 1, or count after this beat == i_max_size (overrun flag set if i_last = 0). Go DECIDE; latch i_stage_threshold.
- Saturation: sum clamps to [-2^(SUM_WIDTH-1), 2^(SUM_WIDTH-1)-1]; never wraps.
- DECIDE: register o_pass, o_overrun, o_stage_sum; go RESULT.
- RESULT: o_result_valid = 1, outputs stable; on i_result_ready go IDLE, clear overrun flag.
- i_valid without acceptance (o_ready = 0) is ignored; upstream must hold data.
- Reset mid-stage: partial sum discarded; no result emitted.

## Timing
- Reset values: o_ready 0 while reset asserted, 1 first cycle after release; o_result_valid 0, o_pass 0, o_overrun 0, o_stage_sum 0; state IDLE.
- Throughput: one beat per cycle in IDLE/ACCUM.
- Latency: final beat accepted at edge E; o_result_valid high after edge E+1 (DECIDE at E..E+1).
- Result accepted at edge R (valid & ready); o_result_valid low and o_ready high after R; next beat acceptable at R+1.
- i_result_ready high before valid has no effect; valid never drops without acceptance.
- Single-beat stage (i_last on first beat or i_max_size = 1): same 1-cycle latency.

## Structure
- Shared package: state enum (IDLE/ACCUM/DECIDE/RESULT), default widths, SUM_MIN/SUM_MAX derivation.
- One sub-module natural: haar_weak_vote (combinational compare/select + sign extension), instantiated once.
- Saturating add and FSM in top level.

## Test plan
- 3 beats, (feature,thr,left,right) = (5,10,20,-7),(12,10,20,-7),(0,0,3,4), i_last on 3rd, threshold 16 -> sum 20-7+4=17, o_pass 1, o_overrun 0, valid 1 cycle after final beat.
- Same stage, threshold 18 -> o_pass 0, o_stage_sum 17; hold i_result_ready 0 for 5 cycles -> outputs stable, o_ready 0.
- i_max_size 4, i_last never asserted, votes +1 -> closes after 4th beat, o_stage_sum 4, o_overrun 1.
- 300 beats of vote +127, SUM_WIDTH 16 -> sum saturates at 32767 (no wrap); 300 of -128 -> -32768.
- Reset low mid-stage after 2 beats -> all outputs 0; next stage starts fresh, sum equals only new votes.
- Back-to-back stages with i_result_ready tied 1 -> new beat accepted on cycle after result acceptance, no beat lost.
